// File: rtl/aes_round_ctrl.sv
// AES block sequencer: walks an external single-round datapath through NR rounds,
// folding in the round key from an external key expander after every round.
module aes_round_ctrl #(
   parameter int NR      = 10,
   parameter int RND_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] data_in,
   input  logic [127:0] key0,
   output logic         ready,
   output logic [3:0]   rnd,
   input  logic [127:0] rk_in,
   output logic         dp_load,
   output logic         dp_last,
   output logic [127:0] dp_in,
   input  logic [127:0] dp_out,
   output logic         done,
   output logic [127:0] data_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } fsm_e;

   localparam logic [3:0] NR_C     = 4'(NR);
   localparam logic [3:0] CNT_INIT = 4'(RND_LAT - 1);

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] data_out_q, data_out_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         ready_q, ready_d;
   logic         dp_load_q, dp_load_d;
   logic         dp_last_q, dp_last_d;
   logic         done_q, done_d;
   logic [127:0] rnd_result_s;

   assign rnd_result_s = dp_out ^ rk_in;

   // Next-state logic; the strobes are computed for the state being entered so they register cleanly.
   always_comb begin
      fsm_d      = fsm_q;
      state_d    = state_q;
      data_out_d = data_out_q;
      rnd_d      = rnd_q;
      cnt_d      = cnt_q;
      ready_d    = 1'b0;
      dp_load_d  = 1'b0;
      dp_last_d  = 1'b0;
      done_d     = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            if (start) begin
               state_d   = data_in ^ key0;
               rnd_d     = 4'd1;
               dp_load_d = 1'b1;
               dp_last_d = (NR_C == 4'd1);
               fsm_d     = S_LAUNCH;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_LAUNCH: begin
            cnt_d     = CNT_INIT;
            dp_last_d = (rnd_q == NR_C);
            fsm_d     = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d     = cnt_q - 4'd1;
               dp_last_d = (rnd_q == NR_C);
            end else begin
               state_d = rnd_result_s;
               if (rnd_q < NR_C) begin
                  rnd_d     = rnd_q + 4'd1;
                  dp_load_d = 1'b1;
                  dp_last_d = ((rnd_q + 4'd1) == NR_C);
                  fsm_d     = S_LAUNCH;
               end else begin
                  // rnd drops to 0 on entry so it already reads 0 during the done cycle
                  data_out_d = rnd_result_s;
                  rnd_d      = 4'd0;
                  done_d     = 1'b1;
                  fsm_d      = S_DONE;
               end
            end
         end
         S_DONE: begin
            rnd_d   = 4'd0;
            ready_d = 1'b1;
            fsm_d   = S_IDLE;
         end
         default: begin
            rnd_d   = 4'd0;
            cnt_d   = 4'd0;
            ready_d = 1'b1;
            fsm_d   = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q      <= S_IDLE;
         state_q    <= 128'd0;
         data_out_q <= 128'd0;
         rnd_q      <= 4'd0;
         cnt_q      <= 4'd0;
         ready_q    <= 1'b1;
         dp_load_q  <= 1'b0;
         dp_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         data_out_q <= data_out_d;
         rnd_q      <= rnd_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         dp_load_q  <= dp_load_d;
         dp_last_q  <= dp_last_d;
         done_q     <= done_d;
      end
   end

   assign ready    = ready_q;
   assign rnd      = rnd_q;
   assign dp_load  = dp_load_q;
   assign dp_last  = dp_last_q;
   assign dp_in    = state_q;
   assign done     = done_q;
   assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: two instances (RND_LAT=1 and RND_LAT=3) driven by a
// behavioural AES round datapath and key expander built from GF(2^8) arithmetic.
module tb_aes_round_ctrl;

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] JUNK = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

   logic         clk;
   logic         rst_n;
   logic         start_a, start_b;
   logic [127:0] data_in, key0;
   logic         ready_a, ready_b;
   logic [3:0]   rnd_a, rnd_b;
   logic [127:0] rk_in_a, rk_in_b;
   logic         dp_load_a, dp_load_b;
   logic         dp_last_a, dp_last_b;
   logic [127:0] dp_in_a, dp_in_b;
   logic [127:0] dp_out_a, dp_out_b;
   logic         done_a, done_b;
   logic [127:0] data_out_a, data_out_b;

   logic [7:0]   sbox_t [256];
   logic [127:0] rkeys  [16];
   logic [127:0] res_a, res_b;
   int           age_a, age_b;
   int           cyc;
   int           passes, total;
   int           ld_n, done_n_a, done_n_b;
   int           ld_cyc [64];
   logic [3:0]   ld_rnd [64];
   logic         ld_last [64];

   aes_round_ctrl #(.NR(10), .RND_LAT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_in), .key0(key0),
      .ready(ready_a), .rnd(rnd_a), .rk_in(rk_in_a), .dp_load(dp_load_a),
      .dp_last(dp_last_a), .dp_in(dp_in_a), .dp_out(dp_out_a), .done(done_a),
      .data_out(data_out_a)
   );

   aes_round_ctrl #(.NR(10), .RND_LAT(3)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_in), .key0(key0),
      .ready(ready_b), .rnd(rnd_b), .rk_in(rk_in_b), .dp_load(dp_load_b),
      .dp_last(dp_last_b), .dp_in(dp_in_b), .dp_out(dp_out_b), .done(done_b),
      .data_out(data_out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      logic [15:0] w;
      w = {a, a} << n;
      return w[15:8];
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ rkeys[0];
      for (int r = 1; r <= 10; r++) s = aes_round(s, (r == 10)) ^ rkeys[r];
      return s;
   endfunction

   task automatic init_model(input logic [127:0] key);
      logic [7:0]  a, inv, rc;
      logic [31:0] w [44];
      logic [31:0] tmp;
      for (int v = 0; v < 256; v++) begin
         a   = 8'(v);
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gmul(inv, a);
         sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h000000};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= 10) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         rkeys[r] = 128'd0;
      end
   endtask

   assign rk_in_a = rkeys[rnd_a];
   assign rk_in_b = rkeys[rnd_b];

   // Round datapath models: result is visible only in the cycle RND_LAT edges after dp_load.
   always @(posedge clk) begin
      if (dp_load_a) begin
         res_a <= aes_round(dp_in_a, dp_last_a);
         age_a <= 1;
      end else if (age_a != 0) begin
         age_a <= age_a + 1;
      end
      if (dp_load_b) begin
         res_b <= aes_round(dp_in_b, dp_last_b);
         age_b <= 1;
      end else if (age_b != 0) begin
         age_b <= age_b + 1;
      end
   end

   assign dp_out_a = (age_a == 1) ? res_a : JUNK;
   assign dp_out_b = (age_b == 3) ? res_b : JUNK;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (dp_load_a && ld_n < 64) begin
         ld_cyc[ld_n]  = cyc;
         ld_rnd[ld_n]  = rnd_a;
         ld_last[ld_n] = dp_last_a;
         ld_n++;
      end
      if (done_a) done_n_a++;
      if (done_b) done_n_b++;
   endtask

   task automatic wait_done(input bit sel_b, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if ((sel_b ? done_b : done_a) == 1'b1) begin
            at = cyc;
            break;
         end
         step();
      end
   endtask

   initial begin
      int acc, t, n0, d0, bad, found;
      passes = 0; total = 0; ld_n = 0; done_n_a = 0; done_n_b = 0;
      init_model(KEY);
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; data_in = 128'd0; key0 = KEY;
      step(); step();
      chk("rst_ready_a", 128'(ready_a), 128'(1));
      chk("rst_ready_b", 128'(ready_b), 128'(1));
      chk("rst_done", 128'(done_a), 128'(0));
      chk("rst_dp_load", 128'(dp_load_a), 128'(0));
      chk("rst_dp_last", 128'(dp_last_a), 128'(0));
      chk("rst_rnd", 128'(rnd_a), 128'(0));
      chk("rst_data_out", data_out_a, 128'd0);

      // start coinciding with reset must be dropped
      data_in = PT; start_a = 1'b1; n0 = ld_n;
      step();
      chk("rst_start_ready", 128'(ready_a), 128'(1));
      start_a = 1'b0; rst_n = 1'b1;
      repeat (3) step();
      chk("rst_start_no_load", 128'(ld_n - n0), 128'(0));
      chk("rst_start_idle", 128'(ready_a), 128'(1));

      // FIPS-197 C.1 block with sequencing checks
      n0 = ld_n; d0 = done_n_a;
      start_a = 1'b1; data_in = PT; acc = cyc + 1;
      step();
      start_a = 1'b0; data_in = JUNK;
      chk("b1_ready_low", 128'(ready_a), 128'(0));
      chk("b1_rnd1", 128'(rnd_a), 128'(1));
      chk("b1_dp_in", dp_in_a, PT ^ KEY);
      wait_done(1'b0, 60, t);
      chk("b1_latency", 128'(t - acc), 128'(20));
      chk("b1_data_out", data_out_a, CT);
      chk("b1_rnd_done", 128'(rnd_a), 128'(0));
      chk("b1_loads", 128'(ld_n - n0), 128'(10));
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (ld_rnd[n0+k] != 4'(k + 1)) bad++;
         if (ld_last[n0+k] != (k == 9)) bad++;
         if (k == 0 && ld_cyc[n0] != acc) bad++;
         if (k > 0 && ld_cyc[n0+k] - ld_cyc[n0+k-1] != 2) bad++;
      end
      chk("b1_seq_errors", 128'(bad), 128'(0));
      step();
      chk("b1_done_pulse", 128'(done_a), 128'(0));
      chk("b1_ready_back", 128'(ready_a), 128'(1));
      chk("b1_done_count", 128'(done_n_a - d0), 128'(1));

      // start held high with data changing mid-block
      n0 = ld_n; d0 = done_n_a;
      start_a = 1'b1; data_in = PT; acc = cyc + 1;
      step();
      data_in = PT2;
      wait_done(1'b0, 60, t);
      chk("hold_latency", 128'(t - acc), 128'(20));
      chk("hold_data_out", data_out_a, CT);
      step();
      chk("hold_idle_ready", 128'(ready_a), 128'(1));
      chk("hold_done_once", 128'(done_n_a - d0), 128'(1));
      step();
      acc = cyc; start_a = 1'b0;
      chk("hold_relaunch", 128'(dp_load_a), 128'(1));
      chk("hold_dp_in2", dp_in_a, PT2 ^ KEY);
      wait_done(1'b0, 60, t);
      chk("hold_latency2", 128'(t - acc), 128'(20));
      chk("hold_data_out2", data_out_a, aes_enc(PT2));
      chk("hold_loads", 128'(ld_n - n0), 128'(20));
      step();

      // reset in round 5 WAIT aborts the block
      start_a = 1'b1; data_in = PT;
      step();
      start_a = 1'b0; found = 0;
      for (int i = 0; i < 60; i++) begin
         if (rnd_a == 4'd5 && !dp_load_a && !ready_a) begin
            found = 1;
            break;
         end
         step();
      end
      chk("r5_reached", 128'(found), 128'(1));
      rst_n = 1'b0; d0 = done_n_a;
      step();
      rst_n = 1'b1;
      chk("r5_ready", 128'(ready_a), 128'(1));
      chk("r5_data_out", data_out_a, 128'd0);
      chk("r5_rnd", 128'(rnd_a), 128'(0));
      repeat (30) step();
      chk("r5_no_done", 128'(done_n_a - d0), 128'(0));
      start_a = 1'b1; data_in = PT; acc = cyc + 1;
      step();
      start_a = 1'b0;
      wait_done(1'b0, 60, t);
      chk("r5_fresh_latency", 128'(t - acc), 128'(20));
      chk("r5_fresh_data_out", data_out_a, CT);
      step(); step();

      // reset on the done edge suppresses the pulse
      start_a = 1'b1; data_in = PT2; acc = cyc + 1;
      step();
      start_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (cyc == acc + 19) break;
         step();
      end
      rst_n = 1'b0; d0 = done_n_a;
      step();
      rst_n = 1'b1;
      chk("rdone_no_pulse", 128'(done_a), 128'(0));
      chk("rdone_ready", 128'(ready_a), 128'(1));
      chk("rdone_data_out", data_out_a, 128'd0);
      repeat (3) step();
      chk("rdone_count", 128'(done_n_a - d0), 128'(0));

      // RND_LAT=3 instance
      d0 = done_n_b;
      start_b = 1'b1; data_in = PT; acc = cyc + 1;
      step();
      start_b = 1'b0; data_in = JUNK;
      chk("lat3_dp_load", 128'(dp_load_b), 128'(1));
      wait_done(1'b1, 100, t);
      chk("lat3_latency", 128'(t - acc), 128'(40));
      chk("lat3_data_out", data_out_b, CT);
      step();
      chk("lat3_done_count", 128'(done_n_b - d0), 128'(1));
      chk("lat3_ready", 128'(ready_b), 128'(1));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
